// File: rtl/tx_fm0_encoder.sv
// FM0 backscatter reply encoder: optional pilot, preamble, data, optional CRC-16, then dummy-1.
// Latency: first preamble half-symbol starts 1 clk after tx_start (trext=0); the pilot goes first when trext=1.
// Backpressure: none; bit_req pulls one bit per symbol, and the source must present it on the next clock.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   tx_start   one-cycle pulse; starts a frame (ignored while tx_busy)
//   trext      sampled with tx_start; 1 = prepend PILOT_LEN data-0 pilot symbols
//   crc_en     sampled with tx_start; 1 = append ~CRC-16 after the data
//   tx_bit_in  serial data bit, sampled one clock after bit_req
//   tx_last    marks the final data bit, sampled with tx_bit_in
//   bit_req    one-cycle strobe asking for the next data bit
//   tx_out     modulator level
//   tx_busy    frame in progress
//   tx_done    one-cycle end-of-frame pulse
module tx_fm0_encoder #(
    parameter int HALF_BIT_CYCLES = 4,
    parameter int PILOT_LEN       = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic tx_start,
    input  logic trext,
    input  logic crc_en,
    input  logic tx_bit_in,
    input  logic tx_last,
    output logic bit_req,
    output logic tx_out,
    output logic tx_busy,
    output logic tx_done
);

    localparam int SYM_W = (PILOT_LEN > 16) ? $clog2(PILOT_LEN) : 4;

    localparam logic [7:0]       HALF_LAST  = 8'(HALF_BIT_CYCLES - 1);
    localparam logic [SYM_W-1:0] PILOT_LAST = SYM_W'(PILOT_LEN - 1);
    localparam logic [SYM_W-1:0] PRE_LAST   = SYM_W'(5);
    localparam logic [SYM_W-1:0] CRC_LAST   = SYM_W'(15);
    // Preamble half-symbols, first half in the MSB: FM0 1,0,1,0,violation,1.
    localparam logic [11:0]      PRE_PAT    = 12'b1101_0010_0011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PILOT,
        S_PREAMBLE,
        S_DATA,
        S_CRC,
        S_DUMMY,
        S_END
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [7:0]       half_cnt;
    logic             half_sel;   // 0 = first half of the symbol, 1 = second half
    logic [SYM_W-1:0] sym_cnt;
    logic             level;      // line level at the end of the previous symbol
    logic             bit_cur;
    logic             last_cur;
    logic             crc_en_q;
    logic [15:0]      crc;

    logic             half_end;
    logic             sym_end;
    logic [3:0]       pre_idx;
    logic             pre_bit;
    logic             crc_bit;
    logic             sym_bit;
    logic             fm0_lvl;
    logic             crc_fb;
    logic [15:0]      crc_nxt;

    assign half_end = (half_cnt == HALF_LAST);
    assign sym_end  = half_end && half_sel;
    assign pre_idx  = {sym_cnt[2:0], half_sel};
    assign pre_bit  = PRE_PAT[4'd11 - pre_idx];
    assign crc_bit  = ~crc[4'd15 - sym_cnt[3:0]];

    assign crc_fb   = crc[15] ^ tx_bit_in;
    assign crc_nxt  = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);

    // Symbol value for the FM0 states; pilot is all zeros, dummy is a one.
    always_comb begin
        sym_bit = 1'b0;
        case (state)
            S_DATA:  sym_bit = bit_cur;
            S_CRC:   sym_bit = crc_bit;
            S_DUMMY: sym_bit = 1'b1;
            default: sym_bit = 1'b0;
        endcase
    end

    // First half always inverts from the previous symbol; the second half
    // inverts again only for a zero. bit_cur is not yet valid during the first
    // data clock, but the first half does not depend on it.
    assign fm0_lvl = half_sel ? (sym_bit ? ~level : level) : ~level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        tx_out  = 1'b0;
        bit_req = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    state_d = trext ? S_PILOT : S_PREAMBLE;
                end
            end
            S_PILOT: begin
                tx_busy = 1'b1;
                tx_out  = fm0_lvl;
                if (sym_end && sym_cnt == PILOT_LAST) begin
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                tx_busy = 1'b1;
                tx_out  = pre_bit;
                if (sym_end && sym_cnt == PRE_LAST) begin
                    bit_req = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_busy = 1'b1;
                tx_out  = fm0_lvl;
                if (sym_end) begin
                    if (last_cur) begin
                        state_d = crc_en_q ? S_CRC : S_DUMMY;
                    end else begin
                        bit_req = 1'b1;
                    end
                end
            end
            S_CRC: begin
                tx_busy = 1'b1;
                tx_out  = fm0_lvl;
                if (sym_end && sym_cnt == CRC_LAST) begin
                    state_d = S_DUMMY;
                end
            end
            S_DUMMY: begin
                tx_busy = 1'b1;
                tx_out  = fm0_lvl;
                if (sym_end) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                tx_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_cnt <= 8'd0;
            half_sel <= 1'b0;
            sym_cnt  <= '0;
            level    <= 1'b0;
            bit_cur  <= 1'b0;
            last_cur <= 1'b0;
            crc_en_q <= 1'b0;
            crc      <= 16'hFFFF;
        end else begin
            // Timing counters restart on every state change so each field
            // begins on a clean half-symbol boundary.
            if (state_d != state) begin
                half_cnt <= 8'd0;
                half_sel <= 1'b0;
                sym_cnt  <= '0;
            end else if (state != S_IDLE && state != S_END) begin
                if (half_end) begin
                    half_cnt <= 8'd0;
                    half_sel <= ~half_sel;
                    if (half_sel) begin
                        sym_cnt <= sym_cnt + SYM_W'(1);
                    end
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end

            // Preamble ends high regardless of what preceded it.
            if (state == S_IDLE) begin
                level <= 1'b0;
            end else if (sym_end) begin
                level <= (state == S_PREAMBLE) ? 1'b1 : tx_out;
            end

            if (state == S_IDLE && tx_start) begin
                crc      <= 16'hFFFF;
                crc_en_q <= crc_en;
            end

            // Data bit arrives one clock after bit_req, i.e. the first clock of the symbol.
            if (state == S_DATA && !half_sel && half_cnt == 8'd0) begin
                bit_cur  <= tx_bit_in;
                last_cur <= tx_last;
                crc      <= crc_nxt;
            end
        end
    end

endmodule
